// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Purpose:
//   Shares one one-hot N_REQ:1 select mux among N_REQ valid/ready producers
//   and feeds a single-entry registered output stage toward one consumer.
//   The arbitration is round-robin by default: the scan starts at a rotating
//   pointer that moves to one past the most recent winner. At most one beat is
//   accepted per cycle. When the output register is draining in the same
//   cycle, a new beat can be accepted, so throughput is one beat per cycle.
//
// Build option:
//   MUX_ARB_FIXED_PRIO_EN
//     When defined, the lowest valid index wins (index 0 has the highest
//     priority) and the pointer stays at 0.
//     When undefined, round-robin arbitration is used.
//     Ports, latency and handshake are the same in both builds.
//
// Parameters:
//   N_REQ   number of requesters (>= 2)
//   W_DATA  data width of one requester beat
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   req_valid_i  per-requester valid
//   req_data_i   packed requester data, slice k = [k*W_DATA +: W_DATA]
//   req_ready_o  per-requester ready (equal to grant_o)
//   grant_o      one-hot mux select of the current winner, 0 if none
//   out_valid_o  output register holds a beat
//   out_data_o   registered winning data
//   out_src_o    registered index of the winning requester
//   out_ready_i  downstream accepts the held beat
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int W_DATA = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*W_DATA-1:0]    req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       out_valid_o,
    output logic [W_DATA-1:0]          out_data_o,
    output logic [$clog2(N_REQ)-1:0]   out_src_o,
    input  logic                       out_ready_i
);

    localparam int SRC_W = $clog2(N_REQ);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W_DATA-1:0]  data_q, data_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;

    logic               load_en;
    logic               found;
    logic [SRC_W-1:0]   winner;
    logic [N_REQ-1:0]   win_onehot;
    logic               accept;
    logic [W_DATA-1:0]  mux_data;
    logic [W_DATA-1:0]  masked_data [N_REQ];

    // The output register can take a new beat if it is empty or if it is
    // draining this cycle.
    assign load_en = (state_q == ST_EMPTY) || out_ready_i;

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
`ifdef MUX_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                found  = 1'b1;
                winner = SRC_W'(k);
            end
        end
    end
`else
    // Scan ptr, ptr+1, ... with modulo wrap. The first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int idx;
            idx = int'(ptr_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end
`endif

    // One-hot decode of the winner. Per-lane data masking forms the AND-OR mux.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign win_onehot[gi]  = found && (winner == SRC_W'(gi));
            assign masked_data[gi] = req_data_i[gi*W_DATA +: W_DATA] & {W_DATA{grant_o[gi]}};
        end
    endgenerate

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            mux_data = mux_data | masked_data[k];
        end
    end

    // Grant is forced to zero while reset is held. This keeps an empty
    // output register from advertising ready during reset.
    assign grant_o     = (load_en && !rst_i) ? win_onehot : '0;
    assign req_ready_o = grant_o;
    assign accept      = |(req_valid_i & req_ready_o);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;

        if (accept) begin
            state_d = ST_FULL;
            data_d  = mux_data;
            src_d   = winner;
`ifdef MUX_ARB_FIXED_PRIO_EN
            ptr_d   = '0;
`else
            if (winner == SRC_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + SRC_W'(1);
            end
`endif
        end else if ((state_q == ST_FULL) && out_ready_i) begin
            // The beat leaves with nothing to replace it.
            // The payload registers keep their stale value.
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid_o = (state_q == ST_FULL);
    assign out_data_o  = data_q;
    assign out_src_o   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
//
// Purpose:
//   Applies directed vectors to mux_rr_arbiter (N_REQ=4, W_DATA=8).
//   Each accepted beat is predicted when its stimulus is driven. A monitor
//   pops these predictions and compares them to every beat that leaves the
//   output register.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int src;
        int data;
    } beat_t;

    beat_t exp_q[$];

    mux_rr_arbiter #(.N_REQ(4), .W_DATA(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Run one cycle of stimulus.
    //   Inputs are driven just after the rising edge.
    //   Grant and ready are checked on the falling edge.
    //   If the hand-computed grant is nonzero, the predicted beat is queued.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy,
                        input logic [3:0] exp_g, input string name);
        beat_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        @(negedge clk);
        chk({name, "_grant"}, int'(grant), int'(exp_g));
        chk({name, "_ready"}, int'(req_ready), int'(exp_g));
        if (exp_g != 4'b0) begin
            e.src  = 0;
            e.data = 0;
            for (int k = 0; k < 4; k++) begin
                if (exp_g[k]) begin
                    e.src  = k;
                    e.data = int'(d[k*8 +: 8]);
                end
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: a beat leaves whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_unexpected: got src=%0d data=%02h, expected no beat",
                         out_src, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                $display("beat: src=%0d data=%02h (expect src=%0d data=%02h)",
                         out_src, out_data, e.src, e.data);
                chk("beat_src", int'(out_src), e.src);
                chk("beat_data", int'(out_data), e.data);
            end
        end
    end

    localparam logic [31:0] D_ALL = 32'h44332211;

    initial begin
        // Reset. A pending request must not be granted while reset is held.
        #1 rst = 1'b1;
        req_valid = 4'hF;
        req_data  = D_ALL;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_src", int'(out_src), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_ready", int'(req_ready), 0);
        req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        // Single requester 2 with data A5.
        step(4'b0100, 32'h5AA53CC3, 1'b1, 4'b0100, "single");
        step(4'b0000, 32'h5AA53CC3, 1'b1, 4'b0000, "single_drain");
        step(4'b0000, 32'h5AA53CC3, 1'b1, 4'b0000, "idle");
        chk("empty_after_drain", int'(out_valid), 0);

        // Pointer is 3 here. Requesters 3 then 0 win, and the pointer wraps.
        step(4'b1001, 32'hD4C3B2A1, 1'b1, 4'b1000, "wrap_a");
        step(4'b1001, 32'hD4C3B2A1, 1'b1, 4'b0001, "wrap_b");

        // Reset mid-transfer while a beat (src 0) is held.
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        out_ready = 1'b0;
        chk("pre_reset_valid", int'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_src", int'(out_src), 0);
        chk("midrst_data", int'(out_data), 0);
        exp_q.delete();
        req_valid = 4'hF;
        req_data  = D_ALL;
        out_ready = 1'b1;
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        chk("midrst_ready_hold", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'h0;

        // All valid with out_ready held high: sources 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            step(4'hF, D_ALL, 1'b1, g, "fair");
        end

        // Load src 1, then apply backpressure with every requester valid.
        step(4'b0010, D_ALL, 1'b1, 4'b0010, "bp_load");
        for (int i = 0; i < 2; i++) begin
            step(4'hF, D_ALL, 1'b0, 4'b0000, "bp_hold");
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_src", int'(out_src), 1);
            chk("bp_hold_data", int'(out_data), 8'h22);
        end
        // Release: src 1 drains and src 2 loads on the same edge.
        step(4'hF, D_ALL, 1'b1, 4'b0100, "bp_release");

        // No request while FULL with out_ready high: empties and the pointer holds.
        step(4'h0, D_ALL, 1'b1, 4'b0000, "norq");
        step(4'h0, D_ALL, 1'b1, 4'b0000, "norq2");
        chk("norq_empty", int'(out_valid), 0);
        step(4'hF, D_ALL, 1'b1, 4'b1000, "ptr_held");
        step(4'h0, D_ALL, 1'b1, 4'b0000, "final_drain");
        step(4'h0, D_ALL, 1'b1, 4'b0000, "final_idle");
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
